div_hilo_unit: RTL and testbench
================================

// Module: div_hilo_unit
// PURPOSE
//  Execute-stage consumer of the 4-bit alu_op code for the HI/LO path: runs
//  multi-cycle signed DIV (alu_op == `ALU_div) and holds the HI/LO registers
//  read by MFHI/MFLO (`ALU_rs_pass). Sits beside the single-cycle ALU in EX.
//  Asserts stall to the hazard unit while a divide is in flight.
// PARAMETERS
//  WIDTH         32  operand/result width (even, >= 4)
//  ALU_OP_WIDTH   4  width of alu_op, matches the decode-stage encoding
// PORTS
//  clock       in   1              rising-edge clock
//  reset_n     in   1              asynchronous active-low reset
//  issue_valid in   1              EX holds a valid instruction this cycle
//  alu_op      in   ALU_OP_WIDTH   decoded ALU operation of that instruction
//  hilo_read   in   1              EX instruction is MFHI or MFLO
//  flush       in   1              squash in-flight divide (branch/exception)
//  rs_val      in   WIDTH          dividend
//  rt_val      in   WIDTH          divisor
//  busy        out  1              divide in flight (state != IDLE)
//  stall       out  1              hold IF/ID/EX this cycle (combinational)
//  done        out  1              one-cycle pulse: HI/LO just updated
//  hi          out  WIDTH          remainder register
//  lo          out  WIDTH          quotient register
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; hi=0, lo=0, done=0, busy=0;
//    internal remainder/quotient/count cleared. Reset mid-divide aborts it.
//  - Accept: in IDLE, issue_valid && alu_op==`ALU_div && !flush -> latch
//    |rs_val|, |rt_val|, sign flags; count=0; go RUN next edge.
//  - States: IDLE -> RUN (WIDTH cycles, one restoring-division bit per
//    cycle, MSB first) -> FIXUP (1 cycle: apply signs, write hi/lo, done=1)
//    -> IDLE. Issue-to-done latency WIDTH+1 edges; HI/LO visible the cycle
//    after done's edge; next divide accepted no earlier than the cycle after.
//  - Signs: quotient truncates toward zero; remainder takes dividend sign;
//    magnitudes computed unsigned in WIDTH+1 bits, negated in FIXUP.
//  - Divide by zero: lo = all ones, hi = rs_val (defined, no trap).
//  - Overflow (-2^(WIDTH-1) / -1): lo = 0x8000_0000, hi = 0 (WIDTH=32).
//  - stall = (busy && issue_valid && (alu_op==`ALU_div || hilo_read)).
//    Any new DIV or MFHI/MFLO waits until state returns to IDLE; unrelated
//    instructions flow. In FIXUP stall is still 1 (no HI/LO bypass).
//  - flush in RUN or FIXUP: state->IDLE next edge, hi/lo unchanged, no done.
//    flush in IDLE blocks acceptance that cycle. flush beats issue.
//  - Non-DIV alu_op values (including `ALU_undef) never start an operation.
//  - hi/lo change only on FIXUP edge or reset; done is 0 in all other states.
// TESTING
//  1. rs=100, rt=7 DIV issued at cycle 0 -> busy 1..WIDTH+1, done at WIDTH+1,
//     then lo=14, hi=2.
//  2. rs=-100 (0xFFFFFF9C), rt=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2);
//     rs=100, rt=-7 -> lo=-14, hi=2.
//  3. rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234; rs=0x80000000, rt=-1 ->
//     lo=0x80000000, hi=0.
//  4. DIV in flight, hilo_read=1 at cycle 5 -> stall=1 until IDLE; second DIV
//     issued mid-run stalls and starts the cycle after first done.
//  5. flush at cycle 10 of a divide -> IDLE next cycle, no done, hi/lo keep
//     prior values (e.g. 2/14 from test 1).
//  6. reset_n low at cycle 12 of a divide (async, mid-cycle) -> hi=lo=0,
//     busy=0 immediately; new DIV after release completes normally.

Source files
------------

// File: rtl/div_hilo_unit.sv
// HI/LO unit: signed restoring divide; issue-to-done WIDTH+1 cycles, HI/LO written at the end of the done cycle.
// No input handshake: while busy, stall holds any DIV or MFHI/MFLO in EX; flush squashes the divide in flight.
module div_hilo_unit #(
  parameter int                      WIDTH        = 32,
  parameter int                      ALU_OP_WIDTH = 4,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_DIV      = ALU_OP_WIDTH'(4'hA)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    issue_valid,
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic                    hilo_read,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        rs_val,
  input  logic [WIDTH-1:0]        rt_val,
  output logic                    busy,
  output logic                    stall,
  output logic                    done,
  output logic [WIDTH-1:0]        hi,
  output logic [WIDTH-1:0]        lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q, r_neg_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             is_div, accept, last_bit, ge;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   trial, diff;

  assign is_div   = issue_valid && (alu_op == ALU_DIV);
  assign accept   = (state_q == S_IDLE) && is_div && !flush;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (flush) state_d = S_IDLE;
               else if (last_bit) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    stall = busy && (is_div || (issue_valid && hilo_read));
    done  = (state_q == S_FIXUP) && !flush;
  end

  // One restoring step: the borrow out of diff says whether the divisor fits.
  always_comb begin
    rs_mag = rs_val[WIDTH-1] ? -rs_val : rs_val;
    rt_mag = rt_val[WIDTH-1] ? -rt_val : rt_val;
    trial  = {rem_q, quo_q[WIDTH-1]};
    diff   = trial - {1'b0, dvs_q};
    ge     = !diff[WIDTH];
    rem_d  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      rem_q   <= '0;
      quo_q   <= rs_mag;
      dvs_q   <= rt_mag;
      cnt_q   <= '0;
      q_neg_q <= rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
      r_neg_q <= rs_val[WIDTH-1];
      dz_q    <= (rt_val == '0);
    end else if (state_q == S_RUN) begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Divide-by-zero remainder already equals |rs|, so the sign fix restores rs itself.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_FIXUP && !flush) begin
      hi_q <= r_neg_q ? -rem_q : rem_q;
      lo_q <= dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_div_hilo_unit.sv
// Bench for div_hilo_unit: vector table through a scoreboard, then stall, flush and reset sequences.
module tb_div_hilo_unit;
  localparam int         W         = 32;
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_RSPASS = 4'h3;
  localparam logic [3:0] OP_DIV    = 4'hA;
  localparam logic [3:0] OP_UNDEF  = 4'hF;

  logic          clock, reset_n, issue_valid, hilo_read, flush;
  logic [3:0]    alu_op;
  logic [W-1:0]  rs_val, rt_val, hi, lo;
  logic          busy, stall, done;

  typedef struct { logic [31:0] rs; logic [31:0] rt; logic [31:0] hi; logic [31:0] lo; } vec_t;
  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  div_hilo_unit #(.WIDTH(W), .ALU_OP_WIDTH(4), .ALU_DIV(OP_DIV)) dut (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .alu_op(alu_op),
    .hilo_read(hilo_read), .flush(flush), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    alu_op      = OP_ADD;
    hilo_read   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drive_div(input logic [31:0] rs, input logic [31:0] rt);
    issue_valid = 1'b1;
    alu_op      = OP_DIV;
    rs_val      = rs;
    rt_val      = rt;
  endtask

  task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, " hi"}, hi, e.hi);
      check({name, " lo"}, lo, e.lo);
    end
  endtask

  // Issue at one negedge; count cycles until done is sampled; check HI/LO the cycle after.
  task automatic run_div(input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int n;
    @(negedge clock);
    drive_div(rs, rt);
    push_exp(ehi, elo);
    @(negedge clock);
    idle_inputs();
    check({name, " busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({name, " latency"}, n, W + 1);
    @(negedge clock);
    check({name, " done_pulse"}, 32'(done), 32'd0);
    check({name, " busy_after"}, 32'(busy), 32'd0);
    pop_check(name);
  endtask

  initial begin
    vec_t vecs[13];
    int   c;
    int   done_cnt;

    vecs[0]  = '{32'd100,        32'd7,          32'd2,          32'd14};
    vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   32'hFFFFFFF2};
    vecs[2]  = '{32'd100,        32'hFFFFFFF9,   32'd2,          32'hFFFFFFF2};
    vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14};
    vecs[4]  = '{32'h00001234,   32'd0,          32'h00001234,   32'hFFFFFFFF};
    vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    vecs[6]  = '{32'd7,          32'd100,        32'd7,          32'd0};
    vecs[7]  = '{32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF};
    vecs[8]  = '{32'h7FFFFFFF,   32'd1,          32'd0,          32'h7FFFFFFF};
    vecs[9]  = '{32'h80000000,   32'd2,          32'd0,          32'hC0000000};
    vecs[10] = '{32'd12345678,   32'd1000,       32'd678,        32'd12345};
    vecs[11] = '{32'h80000000,   32'd0,          32'h80000000,   32'hFFFFFFFF};
    vecs[12] = '{32'hFFFFFFF9,   32'h80000000,   32'hFFFFFFF9,   32'd0};

    // Reset state, with a DIV presented so stall is actually exercised.
    reset_n = 1'b0;
    idle_inputs();
    rs_val = '0;
    rt_val = '0;
    issue_valid = 1'b1;
    alu_op = OP_DIV;
    repeat (3) @(negedge clock);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    idle_inputs();
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_div(vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Non-DIV op and flush-in-IDLE must not start a divide.
    @(negedge clock);
    issue_valid = 1'b1;
    alu_op = OP_UNDEF;
    @(negedge clock);
    check("undef_op busy", 32'(busy), 32'd0);
    drive_div(32'd9, 32'd2);
    flush = 1'b1;
    @(negedge clock);
    idle_inputs();
    check("flush_idle busy", 32'(busy), 32'd0);

    // Stall sequence: MFHI at cycle 5, unrelated op at 6, second DIV held from 7.
    @(negedge clock);
    drive_div(32'd100, 32'd7);
    push_exp(32'd2, 32'd14);
    c = 0;
    @(negedge clock);
    c++;
    idle_inputs();
    repeat (4) begin
      @(negedge clock);
      c++;
    end
    issue_valid = 1'b1;
    alu_op = OP_RSPASS;
    hilo_read = 1'b1;
    #1 check("mfhi stall", 32'(stall), 32'd1);
    @(negedge clock);
    c++;
    alu_op = OP_ADD;
    hilo_read = 1'b0;
    #1 check("unrelated stall", 32'(stall), 32'd0);
    @(negedge clock);
    c++;
    drive_div(32'd50, 32'd5);
    #1 check("div2 stall", 32'(stall), 32'd1);
    while (!done && c < 100) begin
      @(negedge clock);
      c++;
    end
    check("div1 latency", c, W + 1);
    check("fixup stall", 32'(stall), 32'd1);
    @(negedge clock);
    c++;
    check("idle stall", 32'(stall), 32'd0);
    pop_check("div1");
    push_exp(32'd0, 32'd10);
    @(negedge clock);
    c++;
    idle_inputs();
    check("div2 busy", 32'(busy), 32'd1);
    while (!done && c < 150) begin
      @(negedge clock);
      c++;
    end
    check("div2 done_cycle", c, 2 * (W + 1) + 1);
    @(negedge clock);
    pop_check("div2");

    // Flush during RUN at cycle 10: no done, HI/LO keep 2/14.
    run_div(32'd100, 32'd7, 32'd2, 32'd14, "pre_flush");
    @(negedge clock);
    drive_div(32'd9, 32'd2);
    done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      idle_inputs();
      if (done) done_cnt++;
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_run busy", 32'(busy), 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    check("flush_run done_count", done_cnt, 0);
    check("flush_run hi", hi, 32'd2);
    check("flush_run lo", lo, 32'd14);

    // Flush landing on the FIXUP cycle suppresses done and the HI/LO write.
    @(negedge clock);
    drive_div(32'd9, 32'd2);
    c = 0;
    @(negedge clock);
    c++;
    idle_inputs();
    while (!done && c < 100) begin
      @(negedge clock);
      c++;
    end
    check("flush_fixup reached", c, W + 1);
    flush = 1'b1;
    #1 check("flush_fixup done", 32'(done), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    check("flush_fixup busy", 32'(busy), 32'd0);
    check("flush_fixup hi", hi, 32'd2);
    check("flush_fixup lo", lo, 32'd14);

    // Asynchronous reset mid-divide at cycle 12.
    @(negedge clock);
    drive_div(32'd100, 32'd7);
    @(negedge clock);
    idle_inputs();
    repeat (11) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset busy", 32'(busy), 32'd0);
    check("async_reset hi", hi, 32'd0);
    check("async_reset lo", lo, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_div(32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, "post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
